gppm_sequencer: RTL and testbench
=================================

Name: gppm_sequencer

Overview:
- Program sequencer that sits directly upstream of the GPPM datapath (register file + ALU) and drives every GPPM control input from an external instruction ROM.
- Fetches one instruction per two cycles, decodes it into raddr1/raddr2/waddr/wen/wdsrc/func/constant, and branches on the datapath's isZero flag.
- Start/busy/done handshake toward the host; illegal-opcode and step-limit watchdog error flags.

Parameters:
- PC_W, 8, program counter width; ROM depth 2^PC_W; pc wraps modulo 2^PC_W
- MAX_STEPS, 1024, maximum instructions executed per run before a forced timeout halt
- STEP_W, 11, step counter width; must satisfy 2^STEP_W > MAX_STEPS

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request; sampled only in IDLE or DONE
- busy  out  1  high in FETCH/EXEC
- done  out  1  high in DONE until next accepted start
- err_illegal  out  1  run halted on undefined opcode; sticky until next start
- err_timeout  out  1  run halted by step limit; sticky until next start
- pc  out  PC_W  ROM address, registered
- instr  in  24  ROM data for pc (combinational ROM read)
- raddr1, raddr2, waddr  out  4  each; to GPPM
- wen  out  1  to GPPM
- wdsrc  out  1  to GPPM; 1 = ALU result, 0 = constant
- func  out  4  to GPPM ALU
- constant  out  32  to GPPM
- isZero  in  1  from GPPM ALU

Behaviour:
- Instruction fields: op = instr[23:20], a = [19:16], b = [15:12], d = [11:8], imm = [7:0].
- Reset (async, rst_n = 0): state IDLE; pc, ir, step_cnt = 0; busy, done, both err flags = 0; all datapath controls = 0.
- FSM states IDLE, FETCH, EXEC, DONE.
  - IDLE/DONE + start = 1 -> FETCH. On that edge: pc = 0, step_cnt = 0, done = 0, err flags cleared.
  - start in FETCH/EXEC is ignored.
- FETCH (1 cycle):
  - If step_cnt == MAX_STEPS: go to DONE, set err_timeout, ir unchanged.
  - Otherwise ir <= instr and go to EXEC.
- EXEC (1 cycle): controls are decoded from ir combinationally. step_cnt++ and next state is FETCH unless stated otherwise below.
  - 0x0 NOP: pc+1.
  - 0x1 ALU: raddr1 = a, raddr2 = b, waddr = d, func = imm[3:0], wdsrc = 1, wen = 1; pc+1.
  - 0x2 LDI: waddr = d, constant = sign-extended imm, wdsrc = 0, wen = 1; pc+1.
  - 0x3 BZ: raddr1 = a, raddr2 = b, func = d, wen = 0. isZero is sampled at the end of EXEC: pc <= imm[PC_W-1:0] if isZero = 1, else pc+1.
  - 0x4 JMP: pc <= imm[PC_W-1:0].
  - 0xF HALT: go to DONE; pc holds.
  - Any other op: go to DONE, set err_illegal, no write.
- Datapath outputs in every state other than EXEC: all 0, wen = 0. wen is therefore high for exactly one cycle per ALU/LDI instruction, and the register write lands at the end of EXEC.
- Latency: 2 cycles per instruction. The first EXEC occurs 2 cycles after start is sampled.
- pc+1 wraps from 2^PC_W-1 to 0.
- HALT and illegal opcodes do not increment step_cnt. step_cnt saturates at MAX_STEPS.
- busy = FETCH | EXEC. done = DONE. busy and done are never both 1.
- Reset asserted mid-run aborts immediately to the reset values above; no partial write is issued after rst_n falls.

Test Plan:
- Reset then idle: all outputs 0; start pulse -> busy = 1 the next cycle, pc = 0, ir loaded at the end of FETCH.
- ROM[0] = 0x2003FE (LDI r3, -2) -> in EXEC: waddr = 3, constant = 0xFFFFFFFE, wdsrc = 0, wen = 1 for exactly 1 cycle; pc = 1 afterward.
- ROM[1] = 0x112307 (ALU) -> raddr1 = 1, raddr2 = 2, waddr = 3, func = 7, wdsrc = 1, wen = 1 for 1 cycle.
- ROM[2] = 0x312510 (BZ):
  - isZero = 1 in EXEC -> next pc = 0x10, wen = 0.
  - Rerun with isZero = 0 -> next pc = 3.
- ROM[3] = 0xF00000 (HALT) -> done = 1, busy = 0, no error flags. Opcode 0x7 instead -> done = 1, err_illegal = 1. A new start clears both flags.
- ROM[0] = 0x400000 (JMP 0), MAX_STEPS = 4 -> exactly 4 EXEC cycles, then done = 1 and err_timeout = 1. Dropping rst_n mid-run returns every output to 0 asynchronously.

Source files
------------

// File: rtl/gppm_sequencer.sv
// gppm_sequencer: program sequencer that drives the GPPM datapath controls.
// Each instruction takes two cycles: FETCH latches the ROM word into ir, and
// EXEC decodes ir into register-file/ALU controls and computes the next pc.
// The host starts a run with start and observes busy/done plus two sticky
// error flags: illegal opcode and step-limit timeout.
module gppm_sequencer #(
  parameter int PC_W      = 8,
  parameter int MAX_STEPS = 1024,
  parameter int STEP_W    = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err_illegal,
  output logic            err_timeout,
  output logic [PC_W-1:0] pc,
  input  logic [23:0]     instr,
  output logic [3:0]      raddr1,
  output logic [3:0]      raddr2,
  output logic [3:0]      waddr,
  output logic            wen,
  output logic            wdsrc,
  output logic [3:0]      func,
  output logic [31:0]     constant,
  input  logic            isZero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_BZ   = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic [23:0]       ir, ir_nxt;
  logic [STEP_W-1:0] step_cnt, step_nxt;
  logic              err_illegal_nxt, err_timeout_nxt;

  // Instruction fields of the latched word.
  logic [3:0]      op, fa, fb, fd;
  logic [7:0]      imm;
  logic [PC_W-1:0] pc_inc, pc_target;

  assign op        = ir[23:20];
  assign fa        = ir[19:16];
  assign fb        = ir[15:12];
  assign fd        = ir[11:8];
  assign imm       = ir[7:0];
  assign pc_inc    = pc + PC_W'(1);      // wraps naturally at 2^PC_W
  assign pc_target = PC_W'(imm);         // branch/jump target, truncated to pc width

  assign busy = (state == S_FETCH) || (state == S_EXEC);
  assign done = (state == S_DONE);

  // Next-state, next register values and EXEC-only datapath controls.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_nxt       = state;
    pc_nxt          = pc;
    ir_nxt          = ir;
    step_nxt        = step_cnt;
    err_illegal_nxt = err_illegal;
    err_timeout_nxt = err_timeout;
    raddr1          = '0;
    raddr2          = '0;
    waddr           = '0;
    wen             = 1'b0;
    wdsrc           = 1'b0;
    func            = '0;
    constant        = '0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt       = S_FETCH;
          pc_nxt          = '0;
          step_nxt        = '0;
          err_illegal_nxt = 1'b0;
          err_timeout_nxt = 1'b0;
        end
      end

      S_FETCH: begin
        if (step_cnt == STEP_LIMIT) begin
          state_nxt       = S_DONE;
          err_timeout_nxt = 1'b1;
        end else begin
          ir_nxt    = instr;
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        // Retired instructions count toward the watchdog; saturate at the limit.
        if (step_cnt != STEP_LIMIT) begin
          step_nxt = step_cnt + STEP_W'(1);
        end
        case (op)
          OP_NOP: begin
            pc_nxt = pc_inc;
          end
          OP_ALU: begin
            raddr1 = fa;
            raddr2 = fb;
            waddr  = fd;
            func   = imm[3:0];
            wdsrc  = 1'b1;
            wen    = 1'b1;
            pc_nxt = pc_inc;
          end
          OP_LDI: begin
            waddr    = fd;
            constant = {{24{imm[7]}}, imm};
            wdsrc    = 1'b0;
            wen      = 1'b1;
            pc_nxt   = pc_inc;
          end
          OP_BZ: begin
            raddr1 = fa;
            raddr2 = fb;
            func   = fd;
            pc_nxt = isZero ? pc_target : pc_inc;
          end
          OP_JMP: begin
            pc_nxt = pc_target;
          end
          OP_HALT: begin
            state_nxt = S_DONE;
            step_nxt  = step_cnt;
          end
          default: begin
            state_nxt       = S_DONE;
            step_nxt        = step_cnt;
            err_illegal_nxt = 1'b1;
          end
        endcase
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Program counter, instruction register, step counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      ir          <= '0;
      step_cnt    <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      ir          <= ir_nxt;
      step_cnt    <= step_nxt;
      err_illegal <= err_illegal_nxt;
      err_timeout <= err_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_gppm_sequencer.sv
// tb_gppm_sequencer: scoreboard bench. For every run, a reference interpreter
// walks the ROM at instruction level and queues the expected per-cycle output
// snapshot; a monitor compares the DUT outputs on each falling edge.
module tb_gppm_sequencer;

  localparam int PC_W      = 8;
  localparam int MAX_STEPS = 4;
  localparam int STEP_W    = 3;
  localparam int DEPTH     = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            busy, done, err_illegal, err_timeout, wen, wdsrc, isZero;
  logic [PC_W-1:0] pc;
  logic [23:0]     instr;
  logic [3:0]      raddr1, raddr2, waddr, func;
  logic [31:0]     constant;

  logic [23:0] rom    [DEPTH];
  logic        iz_tab [DEPTH];

  assign instr  = rom[pc];
  assign isZero = iz_tab[pc];

  gppm_sequencer #(.PC_W(PC_W), .MAX_STEPS(MAX_STEPS), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_timeout(err_timeout), .pc(pc), .instr(instr),
    .raddr1(raddr1), .raddr2(raddr2), .waddr(waddr), .wen(wen), .wdsrc(wdsrc),
    .func(func), .constant(constant), .isZero(isZero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            eil;
    logic            eto;
    logic [PC_W-1:0] pc;
    logic [3:0]      r1;
    logic [3:0]      r2;
    logic [3:0]      wa;
    logic            wen;
    logic            wdsrc;
    logic [3:0]      func;
    logic [31:0]     k;
  } obs_t;

  obs_t act;
  assign act = {busy, done, err_illegal, err_timeout, pc, raddr1, raddr2, waddr,
                wen, wdsrc, func, constant};

  obs_t  exp_q[$];
  obs_t  last_exp;
  bit    mon_en = 1'b0;
  int    n_tests = 0;
  int    n_fail = 0;
  string run_name = "idle";

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Instruction-level reference: interpret the ROM from pc 0 and emit the
  // expected snapshot for each FETCH, each EXEC and the final DONE cycle.
  task automatic build_trace();
    int   p = 0;
    int   steps = 0;
    obs_t r;
    logic [23:0] w;
    logic [3:0]  op;
    exp_q.delete();
    while (1) begin
      r = '0; r.busy = 1'b1; r.pc = p[PC_W-1:0];
      exp_q.push_back(r);                       // FETCH
      if (steps == MAX_STEPS) begin
        r = '0; r.done = 1'b1; r.eto = 1'b1; r.pc = p[PC_W-1:0];
        exp_q.push_back(r);
        break;
      end
      w  = rom[p];
      op = w[23:20];
      r  = '0; r.busy = 1'b1; r.pc = p[PC_W-1:0];
      case (op)
        4'h1: begin
          r.r1 = w[19:16]; r.r2 = w[15:12]; r.wa = w[11:8];
          r.func = w[3:0]; r.wdsrc = 1'b1; r.wen = 1'b1;
        end
        4'h2: begin
          r.wa = w[11:8]; r.wen = 1'b1;
          r.k  = 32'(signed'(w[7:0]));
        end
        4'h3: begin
          r.r1 = w[19:16]; r.r2 = w[15:12]; r.func = w[11:8];
        end
        default: ;
      endcase
      exp_q.push_back(r);                       // EXEC
      if (op == 4'hF || op > 4'h4) begin
        r = '0; r.done = 1'b1; r.eil = (op != 4'hF); r.pc = p[PC_W-1:0];
        exp_q.push_back(r);
        break;
      end
      steps++;
      case (op)
        4'h3:    p = iz_tab[p] ? (int'(w[7:0]) % DEPTH) : ((p + 1) % DEPTH);
        4'h4:    p = int'(w[7:0]) % DEPTH;
        default: p = (p + 1) % DEPTH;
      endcase
    end
    last_exp = exp_q[exp_q.size() - 1];
  endtask

  // Monitor: compare one queued snapshot per cycle while a run is tracked.
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      check(run_name, act, exp_q.pop_front());
    end
  end

  // Launch one run; optionally hold start high into FETCH to show it is ignored.
  task automatic run_program(input string name, input bit poke);
    run_name = name;
    build_trace();
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = poke;
    mon_en = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d snapshots still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    mon_en = 1'b0;
    @(negedge clk) check({name, "_hold"}, act, last_exp);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) begin
      rom[i]    = 24'h000000;
      iz_tab[i] = 1'b0;
    end
  endtask

  task automatic random_rom();
    for (int i = 0; i < DEPTH; i++) begin
      logic [23:0] w;
      w = 24'($urandom);
      case ($urandom_range(0, 9))
        0:       w[23:20] = 4'h0;
        1, 2:    w[23:20] = 4'h1;
        3, 4, 9: w[23:20] = 4'h2;
        5:       w[23:20] = 4'h3;
        6:       w[23:20] = 4'h4;
        7:       w[23:20] = 4'hF;
        default: w[23:20] = 4'($urandom_range(5, 14));
      endcase
      rom[i]    = w;
      iz_tab[i] = 1'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    obs_t zero;
    zero = '0;
    clear_rom();

    // Reset and idle behaviour.
    #12 check("reset_outputs", act, zero);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) check("idle_outputs", act, zero);
    @(negedge clk) check("idle_hold", act, zero);

    // LDI / ALU / BZ taken / HALT at the branch target.
    rom[0]     = 24'h2003FE;
    rom[1]     = 24'h112307;
    rom[2]     = 24'h312510;
    rom[3]     = 24'hF00000;
    rom[8'h10] = 24'hF00000;
    iz_tab[2]  = 1'b1;
    run_program("bz_taken", 1'b0);

    // Same program, branch not taken; start held into FETCH.
    iz_tab[2] = 1'b0;
    run_program("bz_not_taken", 1'b1);

    // Illegal opcode at pc 3, then a clean rerun clears the flag.
    rom[3] = 24'h700000;
    run_program("illegal_op", 1'b0);
    rom[3] = 24'hF00000;
    run_program("flags_cleared", 1'b0);

    // Tight loop hits the step limit.
    clear_rom();
    rom[0] = 24'h400000;
    run_program("jmp_timeout", 1'b0);

    // Jump to the top of the ROM so pc+1 wraps to 0.
    rom[0]   = 24'h4000FF;
    rom[255] = 24'h000000;
    run_program("pc_wrap", 1'b0);

    // Randomised programs.
    for (int n = 0; n < 40; n++) begin
      random_rom();
      run_program($sformatf("rand%0d", n), 1'($urandom));
    end

    // Asynchronous reset in the middle of a run.
    clear_rom();
    rom[0] = 24'h2003FE;
    rom[1] = 24'h400000;
    run_name = "pre_reset";
    build_trace();
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    #1 check("reset_async", act, zero);
    @(negedge clk) check("reset_held", act, zero);
    rst_n = 1'b1;
    @(negedge clk) check("reset_release_idle", act, zero);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
